ir_prefetch_queue: RTL and testbench
====================================

Name: ir_prefetch_queue

Overview:
- Parametrised successor to the multi-cycle CPU's instruction register.
- Places a DEPTH-entry prefetch FIFO of {pc, instruction} pairs in front of the IR, so the memory side can fetch ahead of the control FSM.
- The control FSM still pulses irwrite to load the IR. The IR additionally carries a valid flag, the instruction's PC, and pre-split MIPS fields for the decoder.

Parameters:
- INST_W, 32, instruction width in bits; field slicing is defined only for 32.
- PC_W, 32, width of the PC tag carried with each instruction.
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- flush  input  1  discard all queued entries and invalidate the IR (branch/jump/exception redirect)
- in_valid  input  1  fetch side presents in_inst/in_pc
- in_inst  input  INST_W  fetched instruction
- in_pc  input  PC_W  address of in_inst
- in_ready  output  1  queue can accept an entry this cycle
- irwrite  input  1  control FSM request to load the IR from the queue head
- inst_out  output  INST_W  IR contents
- pc_out  output  PC_W  PC of inst_out
- ir_valid  output  1  inst_out holds a real instruction
- op  output  6  inst_out[31:26]
- rs  output  5  inst_out[25:21]
- rt  output  5  inst_out[20:16]
- rd  output  5  inst_out[15:11]
- shamt  output  5  inst_out[10:6]
- funct  output  6  inst_out[5:0]
- imm  output  16  inst_out[15:0]
- count  output  $clog2(DEPTH)+1  current number of queued entries

Behaviour:
- Reset: one clock, asynchronous and active-high, clk and rst.
- On rst: inst_out=0 (NOP), pc_out=0, ir_valid=0, count=0, rd/wr pointers=0, in_ready=1.
- Push: in_valid && in_ready at a rising edge writes mem[wr_ptr]. wr_ptr increments modulo DEPTH.
- Pop: irwrite && count!=0 at a rising edge loads inst_out/pc_out from mem[rd_ptr] and sets ir_valid=1. rd_ptr increments modulo DEPTH.
- irwrite with count==0: inst_out/pc_out hold their values and ir_valid goes 0. This is an underflow; the FSM must wait.
- irwrite=0: IR holds all contents, including ir_valid.
- in_ready is registered-state combinational: in_ready = (count != DEPTH). There is no combinational path from irwrite.
- Full plus simultaneous pop: the push is still refused that cycle.
- No bypass: an entry pushed at edge N can load the IR no earlier than edge N+1. Minimum fetch-to-IR latency is 2 edges.
- Simultaneous push and pop, with count neither 0 nor DEPTH: both happen and count is unchanged.
- Simultaneous push and pop with count==0: the push happens, the pop underflows as above, and count becomes 1.
- Flush has priority over push and pop in the same cycle. The result is count=0, pointers=0, ir_valid=0, inst_out=0, pc_out=0. The same-cycle in_valid entry is dropped.
- Field outputs are purely combinational slices of inst_out. With inst_out=0 they are all zero.
- count changes only by -1, 0 or +1 per edge. It never exceeds DEPTH and never goes below 0; assertions check both bounds.
- Storage contents are not reset; only pointers and count are.
- rst asserted mid-operation clears everything immediately, without waiting for clk.

Decomposition:
- Shared package mips_ir_pkg:
  - field LSB/MSB constants: OP_MSB=31, RS_LSB=21, RT_LSB=16, RD_LSB=11, SHAMT_LSB=6;
  - NOP_INST=32'h0000_0000.
- The decoder reuses mips_ir_pkg.
- One sub-module, ir_fifo: a parametrised circular buffer (mem, pointers, count, full/empty).
  - It takes push/pop/clear and has no knowledge of MIPS.
- ir_prefetch_queue wraps ir_fifo plus the IR register and the field slicing.

Test Plan:
- Reset and idle: assert rst mid-cycle with no clk edge -> inst_out=0, ir_valid=0, count=0, in_ready=1 immediately.
- Fill and drain with DEPTH=4:
  - Push 0x20080005@0x0, 0x20090007@0x4, 0x01095020@0x8 and 0xAC0A0000@0xC with irwrite=0 -> count=4, in_ready=0.
  - A fifth push is refused.
  - Four irwrite pulses -> IR shows the entries in order, with pc_out 0x0, 0x4, 0x8, 0xC.
  - For 0x01095020: op=0, rs=8, rt=9, rd=10, funct=0x20.
- Underflow: irwrite with count=0 after IR holds 0xAC0A0000 -> inst_out unchanged, ir_valid=0, count stays 0.
- Concurrent push/pop at count=2 for 10 cycles with incrementing data -> count stays 2, the IR sequence is strictly in order, and pointers wrap past 3 correctly.
- Flush priority: count=3 with in_valid=1, irwrite=1 and flush=1 in one cycle -> count=0, ir_valid=0, inst_out=0, and the pushed entry never appears.
- No bypass: push 0x3C01ABCD into the empty queue with irwrite=1 on the same edge -> ir_valid=0 after that edge. irwrite on the next edge -> inst_out=0x3C01ABCD, imm=0xABCD.

Source files
------------

// File: rtl/mips_ir_pkg.sv
// mips_ir_pkg
//   Shared MIPS instruction-register definitions. The prefetch queue uses it
//   to slice the IR into fields, and the decoder uses the same constants.
//   No ports; contents are field positions/widths and the NOP encoding.
package mips_ir_pkg;

  // Field positions within a 32-bit MIPS instruction word
  localparam int OP_MSB    = 31;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;

  // Field widths
  localparam int OP_W    = 6;
  localparam int REG_W   = 5;
  localparam int FUNCT_W = 6;
  localparam int IMM_W   = 16;

  // sll $0,$0,0 - the canonical NOP, also the IR value after reset/flush
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

endpackage

// File: rtl/ir_fifo.sv
// ir_fifo
//   Parametrised circular buffer with registered pointers and occupancy.
//   Knows nothing about instructions; entries are opaque WIDTH-bit words.
//   Ports:
//     clk, rst      rising-edge clock, asynchronous active-high reset
//     i_clear       empty the buffer (wins over push and pop)
//     i_push        write i_wdata at the tail if not full
//     i_pop         advance the head if not empty
//     i_wdata       entry to write
//     o_rdata       entry at the head (valid when !o_empty)
//     o_count       number of stored entries, 0..DEPTH
//     o_full        o_count == DEPTH
//     o_empty       o_count == 0
module ir_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rdPtr;
  logic [PW-1:0]    r_wrPtr;
  logic [CW-1:0]    r_count;

  logic w_full;
  logic w_empty;
  logic w_doPush;
  logic w_doPop;

  // Full/empty come only from registered occupancy, so acceptance never
  // depends combinationally on the same-cycle pop request.
  assign w_full   = (r_count == FULL_COUNT);
  assign w_empty  = (r_count == '0);
  assign w_doPush = i_push && !w_full  && !i_clear;
  assign w_doPop  = i_pop  && !w_empty && !i_clear;

  assign o_rdata = r_mem[r_rdPtr];
  assign o_count = r_count;
  assign o_full  = w_full;
  assign o_empty = w_empty;

  // Storage is deliberately not reset; stale entries are unreachable once
  // the pointers and occupancy are cleared.
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + PW'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + PW'(1);
      end
      if (w_doPush && !w_doPop) begin
        r_count <= r_count + CW'(1);
      end else if (w_doPop && !w_doPush) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Occupancy bounds: never above DEPTH, never popped below zero.
  always @(posedge clk) begin
    if (!rst) begin
      assert (r_count <= FULL_COUNT);
      assert (!(w_doPop && (r_count == '0)));
    end
  end

endmodule

// File: rtl/ir_prefetch_queue.sv
// ir_prefetch_queue
//   Instruction register fed by a DEPTH-entry prefetch FIFO of {pc, inst}
//   pairs, so instruction fetch can run ahead of the control FSM.
//   Ports:
//     clk, rst                 rising-edge clock, asynchronous active-high reset
//     flush                    drop all queued entries and invalidate the IR
//     in_valid/in_inst/in_pc   fetch-side entry, accepted when in_ready
//     in_ready                 queue not full (registered state only)
//     irwrite                  load IR from the queue head
//     inst_out/pc_out/ir_valid IR contents, its PC and validity
//     op/rs/rt/rd/shamt/funct/imm  combinational field slices of inst_out
//     count                    queued entries, 0..DEPTH
module ir_prefetch_queue
  import mips_ir_pkg::*;
#(
  parameter int INST_W = 32,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [INST_W-1:0]        in_inst,
  input  logic [PC_W-1:0]          in_pc,
  output logic                     in_ready,
  input  logic                     irwrite,
  output logic [INST_W-1:0]        inst_out,
  output logic [PC_W-1:0]          pc_out,
  output logic                     ir_valid,
  output logic [5:0]               op,
  output logic [4:0]               rs,
  output logic [4:0]               rt,
  output logic [4:0]               rd,
  output logic [4:0]               shamt,
  output logic [5:0]               funct,
  output logic [15:0]              imm,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int ENTRY_W = PC_W + INST_W;

  logic [ENTRY_W-1:0] w_headEntry;
  logic               w_full;
  logic               w_empty;

  logic [INST_W-1:0]  r_inst;
  logic [PC_W-1:0]    r_pc;
  logic               r_irValid;

  ir_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clear (flush),
    .i_push  (in_valid),
    .i_pop   (irwrite),
    .i_wdata ({in_pc, in_inst}),
    .o_rdata (w_headEntry),
    .o_count (count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign in_ready = !w_full;

  // IR register. An irwrite against an empty queue keeps the old word but
  // marks it invalid so the FSM knows to wait. The head is read from FIFO
  // storage only, so a same-edge push can never bypass into the IR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inst    <= INST_W'(NOP_INST);
      r_pc      <= '0;
      r_irValid <= 1'b0;
    end else if (flush) begin
      r_inst    <= INST_W'(NOP_INST);
      r_pc      <= '0;
      r_irValid <= 1'b0;
    end else if (irwrite) begin
      if (!w_empty) begin
        r_inst    <= w_headEntry[INST_W-1:0];
        r_pc      <= w_headEntry[ENTRY_W-1:INST_W];
        r_irValid <= 1'b1;
      end else begin
        r_irValid <= 1'b0;
      end
    end
  end

  assign inst_out = r_inst;
  assign pc_out   = r_pc;
  assign ir_valid = r_irValid;

  assign op    = r_inst[OP_MSB -: OP_W];
  assign rs    = r_inst[RS_LSB +: REG_W];
  assign rt    = r_inst[RT_LSB +: REG_W];
  assign rd    = r_inst[RD_LSB +: REG_W];
  assign shamt = r_inst[SHAMT_LSB +: REG_W];
  assign funct = r_inst[FUNCT_W-1:0];
  assign imm   = r_inst[IMM_W-1:0];

endmodule

// File: tb/tb_ir_prefetch_queue.sv
// tb_ir_prefetch_queue
//   Scoreboard bench for ir_prefetch_queue (DEPTH=4). Accepted pushes are
//   queued as expected {pc, inst}; each successful irwrite pops one and the
//   IR is compared against it, alongside a small occupancy/IR model.
module tb_ir_prefetch_queue;

  localparam int INST_W = 32;
  localparam int PC_W   = 32;
  localparam int DEPTH  = 4;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        in_ready;
  logic        irwrite;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        ir_valid;
  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [2:0]  count;

  int errCount   = 0;
  int checkCount = 0;

  // Bench model
  logic [63:0] sbQ[$];
  int          mCount;
  logic [31:0] expInst;
  logic [31:0] expPc;
  logic        expValid;

  ir_prefetch_queue #(
    .INST_W (INST_W),
    .PC_W   (PC_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_inst  (in_inst),
    .in_pc    (in_pc),
    .in_ready (in_ready),
    .irwrite  (irwrite),
    .inst_out (inst_out),
    .pc_out   (pc_out),
    .ir_valid (ir_valid),
    .op       (op),
    .rs       (rs),
    .rt       (rt),
    .rd       (rd),
    .shamt    (shamt),
    .funct    (funct),
    .imm      (imm),
    .count    (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expVal);
    checkCount++;
    if (obs !== expVal) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, expVal);
    end
  endtask

  task automatic resetModel();
    sbQ.delete();
    mCount   = 0;
    expInst  = 32'h0;
    expPc    = 32'h0;
    expValid = 1'b0;
  endtask

  // Compare every observable output against the model.
  task automatic compareAll();
    checkOutput("count",    64'(count),    64'(mCount));
    checkOutput("in_ready", 64'(in_ready), 64'(mCount != DEPTH));
    checkOutput("ir_valid", 64'(ir_valid), 64'(expValid));
    checkOutput("inst_out", 64'(inst_out), 64'(expInst));
    checkOutput("pc_out",   64'(pc_out),   64'(expPc));
    checkOutput("op",       64'(op),       64'(expInst[31:26]));
    checkOutput("rs",       64'(rs),       64'(expInst[25:21]));
    checkOutput("rt",       64'(rt),       64'(expInst[20:16]));
    checkOutput("rd",       64'(rd),       64'(expInst[15:11]));
    checkOutput("shamt",    64'(shamt),    64'(expInst[10:6]));
    checkOutput("funct",    64'(funct),    64'(expInst[5:0]));
    checkOutput("imm",      64'(imm),      64'(expInst[15:0]));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, check.
  task automatic applyStimulus(input logic vld, input logic [31:0] inst, input logic [31:0] pc,
                               input logic irw, input logic fl);
    int  preCount;
    bit  doPush;
    bit  doPop;
    logic [63:0] head;
    in_valid = vld;
    in_inst  = inst;
    in_pc    = pc;
    irwrite  = irw;
    flush    = fl;
    preCount = mCount;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    irwrite  = 1'b0;
    flush    = 1'b0;
    if (fl) begin
      resetModel();
    end else begin
      doPush = vld && (preCount != DEPTH);
      doPop  = irw && (preCount != 0);
      if (doPop) begin
        head     = sbQ.pop_front();
        expInst  = head[31:0];
        expPc    = head[63:32];
        expValid = 1'b1;
        mCount--;
      end else if (irw) begin
        expValid = 1'b0;
      end
      if (doPush) begin
        sbQ.push_back({pc, inst});
        mCount++;
      end
    end
    compareAll();
  endtask

  initial begin
    rst      = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_inst  = 32'h0;
    in_pc    = 32'h0;
    irwrite  = 1'b0;
    resetModel();

    // Asynchronous reset with no clock edge yet
    #2 rst = 1'b1;
    #1;
    $display("[TB] reset without clock edge");
    compareAll();
    #4 rst = 1'b0;

    // Fill to DEPTH, then attempt a fifth push
    $display("[TB] fill and drain");
    applyStimulus(1'b1, 32'h20080005, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h20090007, 32'h4, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h01095020, 32'h8, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hAC0A0000, 32'hC, 1'b0, 1'b0);
    checkOutput("fullCount", 64'(count), 64'd4);
    checkOutput("fullReady", 64'(in_ready), 64'd0);
    applyStimulus(1'b1, 32'hDEADBEEF, 32'h10, 1'b0, 1'b0);
    checkOutput("refusedCount", 64'(count), 64'd4);

    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("rtypeOp",    64'(op),    64'd0);
    checkOutput("rtypeRs",    64'(rs),    64'd8);
    checkOutput("rtypeRt",    64'(rt),    64'd9);
    checkOutput("rtypeRd",    64'(rd),    64'd10);
    checkOutput("rtypeFunct", 64'(funct), 64'h20);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("lastPc", 64'(pc_out), 64'hC);

    // Underflow keeps the IR word but invalidates it
    $display("[TB] underflow");
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("underflowInst", 64'(inst_out), 64'hAC0A0000);

    // Steady-state concurrent push/pop at count=2, wrapping the pointers
    $display("[TB] concurrent push/pop");
    applyStimulus(1'b1, 32'h00001000, 32'h100, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00001001, 32'h104, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 32'h00001002 + 32'(i), 32'h108 + 32'(4 * i), 1'b1, 1'b0);
    end
    checkOutput("steadyCount", 64'(count), 64'd2);

    // Flush beats same-cycle push and pop
    $display("[TB] flush priority");
    applyStimulus(1'b1, 32'h00002000, 32'h180, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hBADBAD00, 32'h200, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // No bypass from a same-edge push into the IR
    $display("[TB] no bypass");
    applyStimulus(1'b1, 32'h3C01ABCD, 32'h300, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("bypassImm", 64'(imm), 64'hABCD);

    // Asynchronous reset in the middle of operation
    $display("[TB] mid-operation reset");
    applyStimulus(1'b1, 32'h00003000, 32'h400, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00003001, 32'h404, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    resetModel();
    compareAll();
    #2 rst = 1'b0;
    applyStimulus(1'b1, 32'h11112222, 32'h500, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
